// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_mem_pkg
// Opcodes, FSM states and decode helpers for the MEM-stage access unit.
// Rev     : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
    endfunction

    // Sub-word stores need the old word first.
    function automatic logic is_rmw_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
        return (((op == OP_LW) || (op == OP_SW)) && (k != 2'b00)) ||
               (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && k[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Big-endian load extract/merge and sub-word store merge of one bus word.
// Rev    : 1.0
// ============================================================================
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] rt_data,
    input  logic [5:0]  opcode,
    input  logic [1:0]  k,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic [4:0]  lshift;
    logic [4:0]  rshift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte k sits at bit 8*(3-k) because offset 0 is the most significant byte.
    assign lshift   = {k, 3'b000};
    assign rshift   = 5'd24 - lshift;
    assign byte_sel = word[rshift +: 8];
    assign half_sel = k[1] ? word[15:0] : word[31:16];

    always_comb begin
        load_data = word;
        case (opcode)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            OP_LWL:  load_data = (word << lshift) | (rt_data & ~(ONES << lshift));
            OP_LWR:  load_data = (word >> rshift) | (rt_data & ~(ONES >> rshift));
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_data = rt_data;
        case (opcode)
            OP_SB: begin
                store_data = word;
                store_data[rshift +: 8] = rt_data[7:0];
            end
            OP_SH: begin
                store_data = word;
                if (k[1]) begin
                    store_data[15:0] = rt_data[15:0];
                end else begin
                    store_data[31:16] = rt_data[15:0];
                end
            end
            default: store_data = rt_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// MEM-stage load/store engine on a word-wide waitrequest bus (RMW for SB/SH).
// Rev    : 1.0
// ============================================================================
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              addr_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    state_t             state;
    state_t             state_next;
    logic [5:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        rt_q;
    logic               err_q;
    logic [31:0]        load_q;
    logic [31:0]        wdata_q;
    logic [31:0]        align_load;
    logic [31:0]        align_store;

    load_align u_load_align (
        .word       (mem_readdata),
        .rt_data    (rt_q),
        .opcode     (op_q),
        .k          (addr_q[1:0]),
        .load_data  (align_load),
        .store_data (align_store)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        addr_error = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (is_misaligned(opcode, addr[1:0])) begin
                        state_next = ST_DONE;
                    end else if (is_load(opcode) || is_rmw_store(opcode)) begin
                        state_next = ST_READ;
                    end else if (opcode == OP_SW) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = is_rmw_store(op_q) ? ST_WRITE : ST_DONE;
                end
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                addr_error = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once so the pipeline may move on behind us.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= 6'h00;
            addr_q  <= '0;
            rt_q    <= 32'h0;
            err_q   <= 1'b0;
            load_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                op_q   <= opcode;
                addr_q <= addr;
                rt_q   <= rt_data;
                err_q  <= is_misaligned(opcode, addr[1:0]);
                if (opcode == OP_SW) begin
                    wdata_q <= rt_data;
                end
            end
            if ((state == ST_READ) && !mem_waitrequest) begin
                if (is_rmw_store(op_q)) begin
                    wdata_q <= align_store;
                end else begin
                    load_q <= align_load;
                end
            end
        end
    end

    assign load_data     = load_q;
    assign mem_writedata = wdata_q;
    assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};

endmodule
`default_nettype wire
